// File: rtl/ldpc_blk_asm_if.sv
// ---------------------------------------------------------------------------
// ldpc_blk_asm_if
// Bus bundle between the stream-to-LDPC segmenter (master side) and the
// LDPC block assembler (slave side).
//   master : drives i_din/i_valid/i_ldpc_start/i_ldpc_mode/i_st_done,
//            observes every o_* signal
//   slave  : the assembler; consumes i_* and drives o_*
// Clock and reset are not part of the bundle; they stay plain ports.
// ---------------------------------------------------------------------------
interface ldpc_blk_asm_if;
    logic [7:0]  i_din;
    logic        i_valid;
    logic        i_ldpc_start;
    logic [1:0]  i_ldpc_mode;
    logic        i_st_done;
    logic [31:0] o_word;
    logic        o_valid;
    logic        o_sob;
    logic        o_eob;
    logic [1:0]  o_mode;
    logic        o_seg_done;
    logic        o_err;
    logic [15:0] o_blk_cnt;
    logic [15:0] o_pad_cnt;

    modport master (
        output i_din, i_valid, i_ldpc_start, i_ldpc_mode, i_st_done,
        input  o_word, o_valid, o_sob, o_eob, o_mode, o_seg_done, o_err,
               o_blk_cnt, o_pad_cnt
    );

    modport slave (
        input  i_din, i_valid, i_ldpc_start, i_ldpc_mode, i_st_done,
        output o_word, o_valid, o_sob, o_eob, o_mode, o_seg_done, o_err,
               o_blk_cnt, o_pad_cnt
    );
endinterface

// File: rtl/ldpc_blk_asm.sv
// ---------------------------------------------------------------------------
// ldpc_blk_asm
// Cuts the segmenter byte stream into LDPC information blocks whose length
// depends on the latched ldpc mode, packs bytes MSB-first into 32-bit words
// and zero-pads the final short block of a segment to full length.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      ldpc_blk_asm_if.slave
//            in : i_din, i_valid, i_ldpc_start, i_ldpc_mode, i_st_done
//            out: o_word, o_valid, o_sob, o_eob, o_mode, o_seg_done,
//                 o_err (sticky), o_blk_cnt, o_pad_cnt
//
// Build option: define LDPCASM_STATS_EN to get saturating block / pad-byte
// counters on o_blk_cnt / o_pad_cnt; otherwise both are tied to zero.
// ---------------------------------------------------------------------------
module ldpc_blk_asm #(
    parameter int unsigned K_MODE0 = 81,
    parameter int unsigned K_MODE1 = 108,
    parameter int unsigned K_MODE2 = 120,
    parameter int unsigned K_MODE3 = 135
) (
    input logic           clk,
    input logic           reset_n,
    ldpc_blk_asm_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [7:0] k_sel(input logic [1:0] m);
        case (m)
            2'd0:    k_sel = 8'(K_MODE0);
            2'd1:    k_sel = 8'(K_MODE1);
            2'd2:    k_sel = 8'(K_MODE2);
            default: k_sel = 8'(K_MODE3);
        endcase
    endfunction

    // Lane 0 is the most significant byte of the word.
    function automatic logic [31:0] lane_ins(input logic [31:0] w,
                                             input logic [1:0]  l,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (l)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  bcnt_q, bcnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] shreg_q, shreg_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic        sob_q, sob_d;
    logic        eob_q, eob_d;
    logic        seg_done_q, seg_done_d;
    logic        err_q, err_d;
    logic        pend_q, pend_d;   // block closed on the way into DONE: raise seg_done there

    logic        accept_s, restart_s, close_s, emit_s, blk_inc_s, pad_inc_s;
    logic [7:0]  k_s, ins_byte_s;
    logic [31:0] word_s;

    // Effect of accepting one byte (data in FILL, zero in PAD) on the current counters.
    assign k_s        = k_sel(mode_q);
    assign ins_byte_s = (state_q == ST_PAD) ? 8'h00 : bus.i_din;
    assign word_s     = lane_ins(shreg_q, lane_q, ins_byte_s);
    assign close_s    = (bcnt_q == (k_s - 8'd1));
    assign emit_s     = close_s || (lane_q == 2'd3);
    assign blk_inc_s  = eob_d;
    assign pad_inc_s  = accept_s && (state_q == ST_PAD);

    // Next-state, datapath and output computation.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        bcnt_d     = bcnt_q;
        lane_d     = lane_q;
        shreg_d    = shreg_q;
        word_d     = word_q;
        valid_d    = 1'b0;
        sob_d      = 1'b0;
        eob_d      = 1'b0;
        seg_done_d = 1'b0;
        err_d      = err_q;
        pend_d     = pend_q;
        accept_s   = 1'b0;
        restart_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_ldpc_start) begin
                    restart_s = 1'b1;
                end else if (bus.i_valid) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            ST_FILL: begin
                if (bus.i_ldpc_start) begin
                    restart_s = 1'b1;
                    if ((bcnt_q != 8'd0) || (lane_q != 2'd0)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    accept_s = bus.i_valid;
                    // With a byte this cycle the counters end at zero only if it closed the block.
                    if (bus.i_st_done) begin
                        if (bus.i_valid ? close_s : ((bcnt_q == 8'd0) && (lane_q == 2'd0))) begin
                            state_d    = ST_DONE;
                            pend_d     = bus.i_valid;
                            seg_done_d = ~bus.i_valid;
                        end else begin
                            state_d = ST_PAD;
                        end
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_PAD: begin
                if (bus.i_ldpc_start) begin
                    restart_s = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    accept_s = 1'b1;
                    if (bus.i_valid) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (close_s) begin
                        state_d = ST_DONE;
                        pend_d  = 1'b1;
                    end else begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_DONE: begin
                if (bus.i_ldpc_start) begin
                    restart_s = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    seg_done_d = pend_q;
                    pend_d     = 1'b0;
                    state_d    = ST_IDLE;
                    if (bus.i_valid) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A restart drops any partial word and any pending seg_done.
        if (restart_s) begin
            state_d = ST_FILL;
            mode_d  = bus.i_ldpc_mode;
            bcnt_d  = 8'd0;
            lane_d  = 2'd0;
            shreg_d = 32'd0;
            pend_d  = 1'b0;
        end else if (accept_s) begin
            bcnt_d  = close_s ? 8'd0 : (bcnt_q + 8'd1);
            lane_d  = emit_s ? 2'd0 : (lane_q + 2'd1);
            shreg_d = emit_s ? 32'd0 : word_s;
            if (emit_s) begin
                word_d  = word_s;
                valid_d = 1'b1;
                // The word's first byte has bcnt == bcnt_q - lane_q.
                sob_d   = (bcnt_q == {6'd0, lane_q});
                eob_d   = close_s;
            end else begin
                word_d  = word_q;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 2'd0;
            bcnt_q     <= 8'd0;
            lane_q     <= 2'd0;
            shreg_q    <= 32'd0;
            word_q     <= 32'd0;
            valid_q    <= 1'b0;
            sob_q      <= 1'b0;
            eob_q      <= 1'b0;
            seg_done_q <= 1'b0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            bcnt_q     <= bcnt_d;
            lane_q     <= lane_d;
            shreg_q    <= shreg_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            sob_q      <= sob_d;
            eob_q      <= eob_d;
            seg_done_q <= seg_done_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
        end
    end

    assign bus.o_word     = word_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_sob      = sob_q;
    assign bus.o_eob      = eob_q;
    assign bus.o_mode     = mode_q;
    assign bus.o_seg_done = seg_done_q;
    assign bus.o_err      = err_q;

`ifdef LDPCASM_STATS_EN
    logic [15:0] blk_cnt_q, blk_cnt_d, pad_cnt_q, pad_cnt_d;

    // Saturating statistics counters.
    always_comb begin
        if (blk_inc_s && (blk_cnt_q != 16'hFFFF)) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
        end else begin
            blk_cnt_d = blk_cnt_q;
        end
        if (pad_inc_s && (pad_cnt_q != 16'hFFFF)) begin
            pad_cnt_d = pad_cnt_q + 16'd1;
        end else begin
            pad_cnt_d = pad_cnt_q;
        end
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt_q <= 16'd0;
            pad_cnt_q <= 16'd0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            pad_cnt_q <= pad_cnt_d;
        end
    end

    assign bus.o_blk_cnt = blk_cnt_q;
    assign bus.o_pad_cnt = pad_cnt_q;
`else
    logic stats_unused_s;
    assign stats_unused_s = blk_inc_s | pad_inc_s;
    assign bus.o_blk_cnt  = 16'd0;
    assign bus.o_pad_cnt  = 16'd0;
`endif

endmodule
